timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 50000000, clk cycles per 1 s tick (legal >= 2).
REQ-002 Parameter: BLINK_DIV, default 12500000, clk cycles per blink toggle (legal >= 1).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_mode  input  1  synchronous single-cycle pulse; advances mode.
REQ-006 btn_inc  input  1  synchronous single-cycle pulse; increments the field being edited.
REQ-007 cur_h1, cur_h2, cur_m1, cur_m2, cur_s1, cur_s2  input  4 each  live BCD tens/units of hour, minute, second counters.
REQ-008 sec_tick  output  1  single-cycle count enable to the seconds counter.
REQ-009 set_hour, set_min, set_sec  output  1 each  load strobes to the hour/minute/second counters.
REQ-010 set_num1, set_num2  output  4 each  BCD tens/units load value.
REQ-011 blink  output  1  display enable for the field being edited.
REQ-012 mode  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.

Function
REQ-013 FSM states SHALL be RUN, SET_HOUR, SET_MIN, SET_SEC; btn_mode SHALL advance RUN->SET_HOUR->SET_MIN->SET_SEC->RUN, one step per pulse; no other transitions.
REQ-014 set_hour/set_min/set_sec SHALL be registered and high exactly while in the matching SET state, with at most one high at a time; all low in RUN.
REQ-015 On the edge entering a SET state, edit register {e1,e2} SHALL load the matching cur_* pair, so set_num1/set_num2 are valid in the first cycle the strobe is high.
REQ-016 set_num1/set_num2 SHALL equal {e1,e2} at all times; e1/e2 SHALL hold their value in RUN.
REQ-017 btn_inc in a SET state SHALL increment {e1,e2} as BCD on the next edge: units 9->0 with tens +1; hours 23->00; minutes and seconds 59->00.
REQ-018 Edit register values above the field limit (e.g. hour 2:7 loaded from cur_*) SHALL wrap to 00 on the next btn_inc.
REQ-019 btn_inc in RUN SHALL be ignored.
REQ-020 btn_mode and btn_inc in the same cycle: btn_mode SHALL win and btn_inc SHALL be ignored.
REQ-021 Prescaler SHALL count 0..TICK_DIV-1 in RUN only; sec_tick SHALL be high for the one cycle in which the count equals TICK_DIV-1, then the count returns to 0.
REQ-022 In any SET state the prescaler SHALL be held at 0 and sec_tick SHALL be low; after return to RUN the first sec_tick SHALL occur TICK_DIV cycles after the transition edge.
REQ-023 Blink counter SHALL count 0..BLINK_DIV-1 in SET states and toggle blink on wrap; on entry to any SET state the counter SHALL clear and blink SHALL be 1.
REQ-024 In RUN, blink SHALL be 1 constantly.
REQ-025 Outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-026 While rst_n is low: mode=RUN, prescaler=0, blink counter=0, e1=e2=0, sec_tick=0, all set_* strobes=0, blink=1.
REQ-027 Reset asserted mid-edit SHALL abandon the edit immediately; after release the block SHALL be in RUN with the first sec_tick TICK_DIV cycles later.

Verification (TICK_DIV=4, BLINK_DIV=2)
REQ-028 Release reset, no buttons -> sec_tick high on cycles 4, 8, 12 after release; mode=0; blink=1.
REQ-029 cur_h=1:5, btn_mode -> mode=1, set_hour=1, set_num=1/5 the next cycle; 3 btn_inc -> set_num=1/8.
REQ-030 In SET_HOUR with edit 2:3, btn_inc -> 0/0; in SET_MIN with edit 5:9, btn_inc -> 0/0; with edit 0:9, btn_inc -> 1/0.
REQ-031 btn_mode and btn_inc in the same cycle in SET_MIN -> mode=3, set_sec=1, set_num=cur_s, no increment applied.
REQ-032 Four btn_mode pulses from RUN -> mode 1,2,3,0; no sec_tick in SET states; first sec_tick 4 cycles after reaching RUN; blink toggles every 2 cycles while in SET.
REQ-033 Assert rst_n low in SET_SEC with edit 4:2 -> all set_* low, mode=0, set_num=0/0 during reset; after release, first sec_tick at cycle 4.

Source files
------------

// File: rtl/timer_ctrl.sv
// timer_ctrl: run/set controller for an HH:MM:SS clock.
// In RUN it divides clk down to a one-cycle seconds enable. btn_mode steps
// through SET_HOUR, SET_MIN and SET_SEC and back to RUN. In each SET state a
// BCD edit register is loaded from the live counters, btn_inc steps it with
// field wrap, and a load strobe plus a blink enable are driven out.
// The buttons are single-cycle synchronous pulses with no handshake: a pulse
// is consumed on the edge it is sampled, and btn_mode has priority over
// btn_inc when both arrive in the same cycle.
// Every output comes straight from a flop. The FSM state is visible on the
// mode output.
module timer_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_h2,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_m2,
  input  logic [3:0] cur_s1,
  input  logic [3:0] cur_s2,
  output logic       sec_tick,
  output logic       set_hour,
  output logic       set_min,
  output logic       set_sec,
  output logic [3:0] set_num1,
  output logic [3:0] set_num2,
  output logic       blink,
  output logic [1:0] mode
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] presc;
  logic [BW-1:0] bcnt;
  logic [3:0]    e1;
  logic [3:0]    e2;
  logic [3:0]    load1;
  logic [3:0]    load2;
  logic [3:0]    inc1;
  logic [3:0]    inc2;
  logic [7:0]    edit_val;
  logic [7:0]    edit_lim;

  assign mode     = state;
  assign set_num1 = e1;
  assign set_num2 = e2;

  // Next step of the mode cycle, the pair to load on entering that state,
  // and the BCD increment of the edit register against the current field limit.
  always_comb begin
    state_nxt = RUN;
    load1     = 4'd0;
    load2     = 4'd0;
    edit_lim  = 8'd59;
    case (state)
      RUN:      begin state_nxt = SET_HOUR; load1 = cur_h1; load2 = cur_h2; end
      SET_HOUR: begin state_nxt = SET_MIN;  load1 = cur_m1; load2 = cur_m2; edit_lim = 8'd23; end
      SET_MIN:  begin state_nxt = SET_SEC;  load1 = cur_s1; load2 = cur_s2; end
      default:  begin state_nxt = RUN; end
    endcase
    // Decimal value of the edit pair; anything at or past the limit
    // (including over-range values loaded from the counters) wraps to 00.
    edit_val = ({4'd0, e1} * 8'd10) + {4'd0, e2};
    if (edit_val >= edit_lim) begin
      inc1 = 4'd0;
      inc2 = 4'd0;
    end else if (e2 >= 4'd9) begin
      inc1 = e1 + 4'd1;
      inc2 = 4'd0;
    end else begin
      inc1 = e1;
      inc2 = e2 + 4'd1;
    end
  end

  // Mode FSM with edit register, prescaler, blink divider and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      presc    <= '0;
      bcnt     <= '0;
      e1       <= 4'd0;
      e2       <= 4'd0;
      sec_tick <= 1'b0;
      set_hour <= 1'b0;
      set_min  <= 1'b0;
      set_sec  <= 1'b0;
      blink    <= 1'b1;
    end else if (btn_mode) begin
      // Mode change: every state entry restarts the prescaler and the blink
      // phase. Entering RUN keeps the edit value.
      state    <= state_nxt;
      set_hour <= (state_nxt == SET_HOUR);
      set_min  <= (state_nxt == SET_MIN);
      set_sec  <= (state_nxt == SET_SEC);
      presc    <= '0;
      bcnt     <= '0;
      blink    <= 1'b1;
      sec_tick <= 1'b0;
      if (state_nxt != RUN) begin
        e1 <= load1;
        e2 <= load2;
      end
    end else if (state == RUN) begin
      // sec_tick fires on the edge after the count reaches its last value,
      // so the first tick comes TICK_DIV edges after RUN is entered.
      sec_tick <= (presc == TICK_LAST);
      presc    <= (presc == TICK_LAST) ? '0 : presc + TW'(1);
      bcnt     <= '0;
      blink    <= 1'b1;
    end else begin
      sec_tick <= 1'b0;
      presc    <= '0;
      if (btn_inc) begin
        e1 <= inc1;
        e2 <= inc2;
      end
      if (bcnt == BLINK_LAST) begin
        bcnt  <= '0;
        blink <= ~blink;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl with TICK_DIV=4 and BLINK_DIV=2. A reference model
// keeps the mode number, the edit value as a plain decimal number, and the
// cycles elapsed since the last state entry. Expected outputs are derived
// from those values each cycle. Directed scenarios are followed by a
// randomized run with occasional resets.
module tb_timer_ctrl;

  localparam int TD = 4;
  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] cur_h1 = 4'd0, cur_h2 = 4'd0, cur_m1 = 4'd0;
  logic [3:0] cur_m2 = 4'd0, cur_s1 = 4'd0, cur_s2 = 4'd0;
  logic       sec_tick, set_hour, set_min, set_sec, blink;
  logic [3:0] set_num1, set_num2;
  logic [1:0] mode;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int m_mode  = 0;
  int m_val   = 0;
  int cyc_run = 0;
  int cyc_set = 0;

  // Clock and reset.
  always #5 clk = ~clk;

  timer_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_h1(cur_h1), .cur_h2(cur_h2), .cur_m1(cur_m1), .cur_m2(cur_m2),
    .cur_s1(cur_s1), .cur_s2(cur_s2), .sec_tick(sec_tick),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_num1(set_num1), .set_num2(set_num2), .blink(blink), .mode(mode)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Field value of the live counters for a given SET mode.
  function automatic int field_val(input int md);
    case (md)
      1:       return int'(cur_h1) * 10 + int'(cur_h2);
      2:       return int'(cur_m1) * 10 + int'(cur_m2);
      default: return int'(cur_s1) * 10 + int'(cur_s2);
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_val   = 0;
    cyc_run = 0;
    cyc_set = 0;
  endtask

  task automatic model_edge(input logic bm, input logic bi);
    int lim;
    if (bm) begin
      m_mode = (m_mode + 1) % 4;
      if (m_mode != 0) begin
        m_val   = field_val(m_mode);
        cyc_set = 0;
      end else begin
        cyc_run = 0;
      end
    end else if (m_mode == 0) begin
      cyc_run++;
    end else begin
      lim = (m_mode == 1) ? 23 : 59;
      if (bi) m_val = (m_val >= lim) ? 0 : m_val + 1;
      cyc_set++;
    end
  endtask

  // Compare every output against the model.
  task automatic check_all();
    logic exp_tick, exp_blink;
    exp_tick  = (m_mode == 0) && (cyc_run > 0) && (cyc_run % TD == 0);
    exp_blink = (m_mode == 0) ? 1'b1 : (((cyc_set / BD) % 2) == 0);
    check("mode", 32'(mode), 32'(m_mode));
    check("sec_tick", 32'(sec_tick), 32'(exp_tick));
    check("set_hour", 32'(set_hour), 32'(m_mode == 1));
    check("set_min", 32'(set_min), 32'(m_mode == 2));
    check("set_sec", 32'(set_sec), 32'(m_mode == 3));
    check("set_num1", 32'(set_num1), 32'(m_val / 10));
    check("set_num2", 32'(set_num2), 32'(m_val % 10));
    check("blink", 32'(blink), 32'(exp_blink));
  endtask

  // Driver: present buttons for one edge (called at a negedge), then check.
  task automatic step(input logic bm, input logic bi);
    btn_mode = bm;
    btn_inc  = bi;
    @(posedge clk);
    model_edge(bm, bi);
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    check_all();
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_h1 = 4'(h / 10); cur_h2 = 4'(h % 10);
    cur_m1 = 4'(m / 10); cur_m2 = 4'(m % 10);
    cur_s1 = 4'(s / 10); cur_s2 = 4'(s % 10);
  endtask

  // Asynchronous reset asserted between edges, held two cycles, released at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int ticks;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_all();
    rst_n = 1'b1;

    // Free run after reset: ticks on edges 4, 8, 12.
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0);
      ticks += int'(sec_tick);
    end
    check("tick_count_12", 32'(ticks), 32'd3);

    // Enter SET_HOUR from 15, three increments to 18.
    set_cur(15, 34, 42);
    step(1'b1, 1'b0);
    check("hour_load", 32'({set_num1, set_num2}), 32'h15);
    repeat (3) step(1'b0, 1'b1);
    check("hour_inc3", 32'({set_num1, set_num2}), 32'h18);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);

    // Field wraps: 23->00, 59->00, 09->10.
    set_cur(23, 59, 9);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("hour_wrap", 32'({set_num1, set_num2}), 32'h00);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("min_wrap", 32'({set_num1, set_num2}), 32'h00);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("sec_carry", 32'({set_num1, set_num2}), 32'h10);
    step(1'b1, 1'b0);

    // Over-range hour loaded from the counters wraps to 00.
    set_cur(27, 0, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("hour_over", 32'({set_num1, set_num2}), 32'h00);

    // Both buttons in SET_MIN: mode wins, seconds loaded, no increment.
    set_cur(10, 20, 37);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("both_mode", 32'(mode), 32'd3);
    check("both_num", 32'({set_num1, set_num2}), 32'h37);
    step(1'b1, 1'b0);

    // Full mode cycle with idle gaps, then free run.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
    end
    repeat (8) step(1'b0, 1'b0);

    // Reset in the middle of a seconds edit.
    set_cur(12, 34, 42);
    repeat (3) step(1'b1, 1'b0);
    check("pre_reset_num", 32'({set_num1, set_num2}), 32'h42);
    @(negedge clk);
    btn_mode = 1'b0;
    model_edge(1'b0, 1'b0);
    check_all();
    do_reset();
    check("reset_num", 32'({set_num1, set_num2}), 32'h00);
    repeat (8) step(1'b0, 1'b0);

    // Randomized run.
    for (int i = 0; i < 800; i++) begin
      set_cur($urandom_range(0, 29), $urandom_range(0, 65), $urandom_range(0, 65));
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
